brick_grid_tiler: RTL

Upstream stage of the brown-brick bitmap. Maps each raster pixel onto a grid of 32x32 brick tiles and produces the per-pixel `offsetX`/`offsetY`/`InsideRectangle` triple that the brick bitmap consumes. Keeps a one-bit-per-tile brick-present map, and removes a brick when the downstream collision logic reports a hit on it. Removals take effect only at frame boundaries, so a brick is never torn mid-frame. Also tracks the remaining brick count and flags level completion.

---
 rtl/brick_grid_tiler.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/brick_grid_tiler.sv
`default_nettype none
// ============================================================================
// Module      : brick_grid_tiler
// Description : Maps raster pixels onto a 32x32 brick grid and keeps a map of
//               present bricks. Removals are applied only at frame boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module brick_grid_tiler #(
    parameter int GRID_COLS   = 20,
    parameter int GRID_ROWS   = 15,
    parameter int ORIGIN_X    = 0,
    parameter int ORIGIN_Y    = 0,
    parameter int FIRST_ROW   = 2,
    parameter int LAST_ROW    = 5,
    parameter int HIT_LATENCY = 2
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        startOfFrame,
    input  logic        collision,
    input  logic        loadLevel,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        InsideRectangle,
    output logic [8:0]  bricksLeft,
    output logic        levelCleared
);

    localparam int          c_NUM_TILES = GRID_COLS * GRID_ROWS;
    localparam int          c_IDX_W     = (c_NUM_TILES > 1) ? $clog2(c_NUM_TILES) : 1;
    localparam logic [8:0]  c_DEF_COUNT = 9'((LAST_ROW - FIRST_ROW + 1) * GRID_COLS);
    localparam logic [10:0] c_ORG_X     = 11'(ORIGIN_X);
    localparam logic [10:0] c_ORG_Y     = 11'(ORIGIN_Y);
    localparam logic [10:0] c_GRID_W    = 11'(GRID_COLS * 32);
    localparam logic [10:0] c_GRID_H    = 11'(GRID_ROWS * 32);

    function automatic logic [c_NUM_TILES-1:0] f_default_map();
        logic [c_NUM_TILES-1:0] m;
        m = '0;
        for (int r = FIRST_ROW; r <= LAST_ROW; r++) begin
            for (int c = 0; c < GRID_COLS; c++) begin
                m[r * GRID_COLS + c] = 1'b1;
            end
        end
        return m;
    endfunction

    localparam logic [c_NUM_TILES-1:0] c_DEF_MAP = f_default_map();

    logic [c_NUM_TILES-1:0] r_map;
    logic [c_NUM_TILES-1:0] w_map_next;
    logic [8:0]             r_bricks_left;
    logic                   r_level_cleared;
    logic                   r_pend_valid;
    logic [c_IDX_W-1:0]     r_pend_idx;
    logic [c_IDX_W-1:0]     r_pipe_idx [HIT_LATENCY];
    logic                   r_pipe_in  [HIT_LATENCY];
    logic                   r_pipe_vld [HIT_LATENCY];

    logic [10:0]        w_rel_x;
    logic [10:0]        w_rel_y;
    logic               w_in_grid;
    logic [c_IDX_W-1:0] w_tile_idx;
    logic [c_IDX_W-1:0] w_lookup_idx;
    logic               w_inside;
    logic               w_hit;
    logic               w_apply;
    logic               w_capture;

    always_comb begin
        w_rel_x      = pixelX - c_ORG_X;
        w_rel_y      = pixelY - c_ORG_Y;
        w_in_grid    = (pixelX >= c_ORG_X) && (pixelY >= c_ORG_Y) &&
                       (w_rel_x < c_GRID_W) && (w_rel_y < c_GRID_H);
        w_tile_idx   = c_IDX_W'(w_rel_y[10:5]) * c_IDX_W'(GRID_COLS) + c_IDX_W'(w_rel_x[10:5]);
        w_lookup_idx = w_in_grid ? w_tile_idx : '0;
    end

    // A removal only counts if the brick is still there, so the count cannot underflow.
    assign w_apply   = startOfFrame & r_pend_valid & r_map[r_pend_idx];
    assign w_hit     = collision & r_pipe_vld[HIT_LATENCY-1] & r_pipe_in[HIT_LATENCY-1];
    assign w_capture = w_hit & (~r_pend_valid | startOfFrame);

    always_comb begin
        w_map_next = r_map;
        if (loadLevel) begin
            w_map_next = c_DEF_MAP;
        end else if (w_apply) begin
            w_map_next[r_pend_idx] = 1'b0;
        end
    end

    // The pixel presented on a frame/load edge already sees the updated map.
    assign w_inside = w_in_grid & w_map_next[w_lookup_idx];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            offsetX         <= '0;
            offsetY         <= '0;
            InsideRectangle <= 1'b0;
        end else begin
            offsetX         <= w_in_grid ? {6'b0, w_rel_x[4:0]} : 11'd0;
            offsetY         <= w_in_grid ? {6'b0, w_rel_y[4:0]} : 11'd0;
            InsideRectangle <= w_inside;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < HIT_LATENCY; i++) begin
                r_pipe_idx[i] <= '0;
                r_pipe_in[i]  <= 1'b0;
                r_pipe_vld[i] <= 1'b0;
            end
        end else begin
            r_pipe_idx[0] <= w_tile_idx;
            r_pipe_in[0]  <= w_inside;
            r_pipe_vld[0] <= ~loadLevel;
            for (int i = 1; i < HIT_LATENCY; i++) begin
                r_pipe_idx[i] <= r_pipe_idx[i-1];
                r_pipe_in[i]  <= r_pipe_in[i-1];
                r_pipe_vld[i] <= r_pipe_vld[i-1] & ~loadLevel;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_map           <= c_DEF_MAP;
            r_bricks_left   <= c_DEF_COUNT;
            r_level_cleared <= 1'b0;
            r_pend_valid    <= 1'b0;
            r_pend_idx      <= '0;
        end else begin
            r_map <= w_map_next;
            if (loadLevel) begin
                r_bricks_left   <= c_DEF_COUNT;
                r_level_cleared <= 1'b0;
                r_pend_valid    <= 1'b0;
            end else begin
                r_level_cleared <= w_apply && (r_bricks_left == 9'd1);
                if (w_apply) begin
                    r_bricks_left <= r_bricks_left - 9'd1;
                end
                // A frame boundary retires the old hit, so a coincident hit becomes the new one.
                if (w_capture) begin
                    r_pend_valid <= 1'b1;
                    r_pend_idx   <= r_pipe_idx[HIT_LATENCY-1];
                end else if (startOfFrame) begin
                    r_pend_valid <= 1'b0;
                end
            end
        end
    end

    assign bricksLeft   = r_bricks_left;
    assign levelCleared = r_level_cleared;

endmodule
`default_nettype wire
